// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and event record for the PS/2 receiver.
// No logic here: no latency, no backpressure.
package ps2_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

   // Scan codes (set 2) of the keys kept when key filtering is enabled
   localparam logic [7:0] KEY_A     = 8'h1C;
   localparam logic [7:0] KEY_B     = 8'h32;
   localparam logic [7:0] KEY_C     = 8'h21;
   localparam logic [7:0] KEY_D     = 8'h23;
   localparam logic [7:0] KEY_E     = 8'h24;
   localparam logic [7:0] KEY_F     = 8'h2B;
   localparam logic [7:0] KEY_G     = 8'h34;
   localparam logic [7:0] KEY_H     = 8'h33;
   localparam logic [7:0] KEY_I     = 8'h43;
   localparam logic [7:0] KEY_J     = 8'h3B;
   localparam logic [7:0] KEY_1     = 8'h16;
   localparam logic [7:0] KEY_2     = 8'h1E;
   localparam logic [7:0] KEY_3     = 8'h26;
   localparam logic [7:0] KEY_4     = 8'h25;
   localparam logic [7:0] KEY_5     = 8'h2E;
   localparam logic [7:0] KEY_6     = 8'h36;
   localparam logic [7:0] KEY_7     = 8'h3D;
   localparam logic [7:0] KEY_8     = 8'h3E;
   localparam logic [7:0] KEY_9     = 8'h46;
   localparam logic [7:0] KEY_0     = 8'h45;
   localparam logic [7:0] KEY_ENTER = 8'h5A;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } ps2_state_e;

   typedef struct packed {
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } ps2_evt_t;

   function automatic logic ps2_key_kept(input logic [7:0] code);
      case (code)
         KEY_A, KEY_B, KEY_C, KEY_D, KEY_E, KEY_F, KEY_G, KEY_H, KEY_I, KEY_J,
         KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7, KEY_8, KEY_9, KEY_0,
         KEY_ENTER: ps2_key_kept = 1'b1;
         default:   ps2_key_kept = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO with sticky overflow flag.
// Latency: a push is visible on vld_o/dat_o the next cycle.
// Backpressure: push while full and not popping drops the event and sets overflow_o.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clock27,
   input  logic     resetN,
   input  logic     push_i,
   input  ps2_evt_t push_dat_i,
   output logic     vld_o,
   input  logic     rdy_i,
   output ps2_evt_t dat_o,
   output logic     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ps2_evt_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            full, pop, wr_en;

   assign full  = (cnt_q == CW'(DEPTH));
   assign vld_o = (cnt_q != '0);
   assign pop   = vld_o && rdy_i;
   // A pop in the same cycle frees the slot the push needs
   assign wr_en = push_i && (!full || pop);

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q | (push_i && full && !pop);
      if (wr_en && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!wr_en && pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clock27 or negedge resetN) begin
      if (!resetN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clock27) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign dat_o      = vld_o ? mem_q[rd_ptr_q] : '0;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: pin sync/filter, 11-bit deframing, E0/F0 folding, event FIFO.
// Latency: stop-bit fallEdge in cycle N -> evtValid in N+2 (FIFO empty); error pulses in N+2.
// Backpressure: evtReady pops the FIFO; a full FIFO drops events (sticky overflow). KEY_FILTER_EN keeps only A-J, 0-9, Enter.
module ps2_key_receiver
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 27000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clock27,
   input  logic       resetN,
   input  logic       ps2Clk,
   input  logic       ps2Dat,
   output logic       evtValid,
   input  logic       evtReady,
   output logic [7:0] evtCode,
   output logic       evtBreak,
   output logic       evtExt,
   output logic       parityErr,
   output logic       frameErr,
   output logic       overflow
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
   logic                   clk_s, dat_s;

   always_ff @(posedge clock27 or negedge resetN) begin
      if (!resetN) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2Clk};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2Dat};
      end
   end

   assign clk_s = clk_sync_q[SYNC_STAGES-1];
   assign dat_s = dat_sync_q[SYNC_STAGES-1];

   logic           filt_q, filt_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic           fall_edge;

   // fall_edge fires in the cycle whose sample completes a run of FILTER_LEN lows
   always_comb begin
      filt_d    = filt_q;
      fcnt_d    = '0;
      fall_edge = 1'b0;
      if (clk_s != filt_q) begin
         if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_d    = clk_s;
            fall_edge = filt_q;
         end else begin
            fcnt_d = fcnt_q + FCW'(1);
         end
      end
   end

   always_ff @(posedge clock27 or negedge resetN) begin
      if (!resetN) begin
         filt_q <= 1'b1;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   ps2_state_e     state_q, state_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [9:0]     shift_q, shift_d;
   logic [TCW-1:0] tmo_q, tmo_d;
   logic           ext_q, ext_d, brk_q, brk_d;
   logic           parity_err_q, parity_err_d, frame_err_q, frame_err_d;
   logic           push;
   ps2_evt_t       push_evt;
   logic [7:0]     rx_byte;
   logic           parity_ok, stop_ok;

   // After ten shifts: [7:0] data, [8] parity, [9] stop
   assign rx_byte   = shift_q[7:0];
   assign parity_ok = ^shift_q[8:0];
   assign stop_ok   = shift_q[9];

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      tmo_d        = tmo_q;
      ext_d        = ext_q;
      brk_d        = brk_q;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      push         = 1'b0;
      push_evt     = '{code: rx_byte, brk: brk_q, ext: ext_q};
      case (state_q)
         IDLE: begin
            if (fall_edge && !dat_s) begin
               state_d   = RECV;
               bit_cnt_d = 4'd1;
               tmo_d     = '0;
            end
         end
         RECV: begin
            if (fall_edge) begin
               shift_d   = {dat_s, shift_q[9:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               tmo_d     = '0;
               if (bit_cnt_q == 4'd10) state_d = CHECK;
            end else if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
               frame_err_d = 1'b1;
               ext_d       = 1'b0;
               brk_d       = 1'b0;
               bit_cnt_d   = '0;
               state_d     = IDLE;
            end else begin
               tmo_d = tmo_q + TCW'(1);
            end
         end
         CHECK: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (!parity_ok || !stop_ok) begin
               parity_err_d = !parity_ok;
               frame_err_d  = !stop_ok;
               ext_d        = 1'b0;
               brk_d        = 1'b0;
            end else if (rx_byte == PS2_PREFIX_EXT) begin
               ext_d = 1'b1;
            end else if (rx_byte == PS2_PREFIX_BRK) begin
               brk_d = 1'b1;
            end else begin
               ext_d = 1'b0;
               brk_d = 1'b0;
`ifdef KEY_FILTER_EN
               push  = ps2_key_kept(rx_byte);
`else
               push  = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock27 or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         tmo_q        <= '0;
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         tmo_q        <= tmo_d;
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   ps2_evt_t head;

   ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock27    (clock27),
      .resetN     (resetN),
      .push_i     (push),
      .push_dat_i (push_evt),
      .vld_o      (evtValid),
      .rdy_i      (evtReady),
      .dat_o      (head),
      .overflow_o (overflow)
   );

   assign evtCode   = head.code;
   assign evtBreak  = head.brk;
   assign evtExt    = head.ext;
   assign parityErr = parity_err_q;
   assign frameErr  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: table-driven frames, directed corner cases, randomized frames vs a queue model.
// Honours KEY_FILTER_EN when compiled with it.
module tb_ps2_key_receiver;

   localparam int SYNC = 2;
   localparam int FLEN = 8;
   localparam int TMO  = 27000;
   localparam int DEP  = 4;
   localparam int HALF = 20;
   localparam int GL   = 16;
   localparam int LAT  = SYNC + FLEN + 1;
`ifdef KEY_FILTER_EN
   localparam bit FILTER_ON = 1'b1;
`else
   localparam bit FILTER_ON = 1'b0;
`endif
   localparam logic [7:0] KEYS [21] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
      8'h46, 8'h45, 8'h5A};

   logic       clock27 = 1'b0;
   logic       resetN, ps2Clk, ps2Dat, evtReady;
   logic       evtValid, evtBreak, evtExt, parityErr, frameErr, overflow;
   logic [7:0] evtCode;

   int         checks = 0;
   int         failures = 0;
   int         perr_cnt = 0;
   int         ferr_cnt = 0;
   bit         rnd_ready = 1'b0;
   logic [9:0] got_q [$];
   logic [9:0] exp_q [$];

   always #5 clock27 = ~clock27;

   ps2_key_receiver #(
      .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEP)
   ) dut (
      .clock27(clock27), .resetN(resetN), .ps2Clk(ps2Clk), .ps2Dat(ps2Dat),
      .evtValid(evtValid), .evtReady(evtReady), .evtCode(evtCode),
      .evtBreak(evtBreak), .evtExt(evtExt), .parityErr(parityErr),
      .frameErr(frameErr), .overflow(overflow)
   );

   always @(negedge clock27) begin
      if (resetN) begin
         if (evtValid && evtReady) got_q.push_back({evtCode, evtBreak, evtExt});
         if (parityErr) perr_cnt++;
         if (frameErr) ferr_cnt++;
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit kept(input logic [7:0] c);
      bit in_set = 1'b0;
      foreach (KEYS[i]) if (KEYS[i] == c) in_set = 1'b1;
      return !FILTER_ON || in_set;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock27);
      #1;
      if (rnd_ready) evtReady = 1'($urandom_range(0, 1));
   endtask

   // mode 1: check evtValid timing around the stop edge; mode 2: pop in the push cycle
   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                             input logic glitch, input int mode, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2Dat = f[i];
         for (int k = 1; k <= HALF; k++) begin
            tick();
            ps2Clk = !(glitch && k == GL);
         end
         ps2Clk = 1'b0;
         for (int k = 1; k <= HALF; k++) begin
            tick();
            ps2Clk = glitch && k == GL;
            if (i == 10 && mode == 1 && k == LAT - 1) check("latency_before", evtValid, 0);
            if (i == 10 && mode == 1 && k == LAT) begin
               check("latency_valid", evtValid, 1);
               check("latency_head", {evtCode, evtBreak, evtExt}, {d, 2'b00});
            end
            if (i == 10 && mode == 2 && k == LAT - 1) evtReady = 1'b1;
            if (i == 10 && mode == 2 && k == LAT) evtReady = 1'b0;
         end
         ps2Clk = 1'b1;
      end
      repeat (30) tick();
   endtask

   typedef struct packed {
      logic [7:0] code;
      logic bad_par, bad_stop, glitch;
      logic exp_evt, exp_brk, exp_ext, exp_perr, exp_ferr;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] c, input logic bp, input logic bs, input logic g,
                               input logic ev, input logic b, input logic e, input logic pe,
                               input logic fe);
      return '{c, bp, bs, g, ev, b, e, pe, fe};
   endfunction

   vec_t tbl [21];
   logic [7:0] ov [6];

   initial begin
      int p0, f0, waited;
      logic m_ext, m_brk;

      tbl[0]  = mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(8'h1C, 0, 0, 0, 1, 1, 0, 0, 0);
      tbl[2]  = mk(8'hE0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[4]  = mk(8'h75, 0, 0, 0, 1, 1, 1, 0, 0);
      tbl[5]  = mk(8'h1C, 1, 0, 0, 0, 0, 0, 1, 0);
      tbl[6]  = mk(8'h16, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[7]  = mk(8'hE0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[8]  = mk(8'hE0, 0, 0, 1, 0, 0, 0, 0, 0);
      tbl[9]  = mk(8'h5A, 0, 0, 1, 1, 0, 1, 0, 0);
      tbl[10] = mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[11] = mk(8'h1C, 0, 1, 0, 0, 0, 0, 0, 1);
      tbl[12] = mk(8'h32, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[13] = mk(8'hE0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[14] = mk(8'h12, 1, 1, 0, 0, 0, 0, 1, 1);
      tbl[15] = mk(8'h21, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[16] = mk(8'h1D, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[17] = mk(8'hE0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[18] = mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[19] = mk(8'h1D, 0, 0, 0, 1, 1, 1, 0, 0);
      tbl[20] = mk(8'h16, 0, 0, 0, 1, 0, 0, 0, 0);
      ov = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

      resetN = 1'b0; ps2Clk = 1'b1; ps2Dat = 1'b1; evtReady = 1'b0;
      repeat (3) tick();
      check("rst_valid", evtValid, 0);
      check("rst_head", {evtCode, evtBreak, evtExt}, 0);
      check("rst_errs", {parityErr, frameErr}, 0);
      check("rst_ovf", overflow, 0);
      resetN = 1'b1;
      repeat (5) tick();
      check("post_rst_valid", evtValid, 0);

      send_frame(8'h1C, 0, 0, 0, 1, 11);
      check("hold_valid", evtValid, 1);
      evtReady = 1'b1;
      tick();
      check("pop_empty", evtValid, 0);
      evtReady = 1'b0;
      check("pop_count", got_q.size(), 1);
      got_q.delete();

      evtReady = 1'b1;
      for (int i = 0; i < 21; i++) begin
         logic ev;
         p0 = perr_cnt; f0 = ferr_cnt; got_q.delete();
         send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop, tbl[i].glitch, 0, 11);
         ev = tbl[i].exp_evt && kept(tbl[i].code);
         check($sformatf("row%0d_nevt", i), got_q.size(), ev);
         if (ev && got_q.size() > 0)
            check($sformatf("row%0d_evt", i), got_q[0], {tbl[i].code, tbl[i].exp_brk, tbl[i].exp_ext});
         check($sformatf("row%0d_perr", i), perr_cnt - p0, tbl[i].exp_perr);
         check($sformatf("row%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
      end

      send_frame(8'hE0, 0, 0, 0, 0, 11);
      got_q.delete(); f0 = ferr_cnt;
      send_frame(8'h33, 0, 0, 0, 0, 6);
      waited = 0;
      while (ferr_cnt == f0 && waited < TMO + 1000) begin
         tick();
         waited++;
      end
      check("timeout_ferr", ferr_cnt - f0, 1);
      check("timeout_not_early", waited > TMO - 4 * HALF, 1);
      check("timeout_no_evt", got_q.size(), 0);
      send_frame(8'h5A, 0, 0, 0, 0, 11);
      check("after_tmo_n", got_q.size(), 1);
      if (got_q.size() > 0) check("after_tmo_evt", got_q[0], {8'h5A, 2'b00});

      evtReady = 1'b0; got_q.delete();
      for (int i = 0; i < 4; i++) send_frame(ov[i], 0, 0, 0, 0, 11);
      check("full_no_ovf", overflow, 0);
      check("full_head", {evtValid, evtCode}, {1'b1, ov[0]});
      send_frame(ov[4], 0, 0, 0, 2, 11);
      check("pushpop_full_ovf", overflow, 0);
      check("pushpop_popped", got_q.size(), 1);
      send_frame(ov[5], 0, 0, 0, 0, 11);
      check("ovf_set", overflow, 1);
      evtReady = 1'b1;
      repeat (10) tick();
      evtReady = 1'b0;
      check("drain_n", got_q.size(), 5);
      for (int i = 0; i < 5 && i < got_q.size(); i++)
         check($sformatf("drain%0d", i), got_q[i], {ov[i], 2'b00});
      check("ovf_sticky", overflow, 1);
      check("drained_empty", evtValid, 0);

      got_q.delete();
      send_frame(8'h16, 0, 0, 0, 0, 11);
      check("pre_rst_valid", evtValid, 1);
      send_frame(8'hE0, 0, 0, 0, 0, 11);
      send_frame(8'h1C, 0, 0, 0, 0, 5);
      resetN = 1'b0;
      #2;
      check("midrst_valid", evtValid, 0);
      check("midrst_ovf", overflow, 0);
      repeat (3) tick();
      resetN = 1'b1; ps2Clk = 1'b1; ps2Dat = 1'b1;
      repeat (3) tick();
      evtReady = 1'b1;
      send_frame(8'h16, 0, 0, 0, 0, 11);
      check("midrst_n", got_q.size(), 1);
      if (got_q.size() > 0) check("midrst_evt", got_q[0], {8'h16, 2'b00});

      got_q.delete(); exp_q.delete();
      p0 = perr_cnt; f0 = ferr_cnt;
      m_ext = 1'b0; m_brk = 1'b0;
      rnd_ready = 1'b1;
      begin
         int exp_perr = 0;
         int exp_ferr = 0;
         for (int n = 0; n < 30; n++) begin
            logic [7:0] c;
            logic bp, bs;
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) c = 8'hE0;
            else if (r == 1) c = 8'hF0;
            else if (r < 6) c = KEYS[$urandom_range(0, 20)];
            else c = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 11) == 0);
            send_frame(c, bp, bs, 1'($urandom_range(0, 1)), 0, 11);
            if (bp || bs) begin
               exp_perr += int'(bp);
               exp_ferr += int'(bs);
               m_ext = 1'b0; m_brk = 1'b0;
            end else if (c == 8'hE0) m_ext = 1'b1;
            else if (c == 8'hF0) m_brk = 1'b1;
            else begin
               if (kept(c)) exp_q.push_back({c, m_brk, m_ext});
               m_ext = 1'b0; m_brk = 1'b0;
            end
         end
         rnd_ready = 1'b0;
         evtReady = 1'b1;
         repeat (20) tick();
         check("rnd_count", got_q.size(), exp_q.size());
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rnd_evt%0d", i), got_q[i], exp_q[i]);
         check("rnd_perr", perr_cnt - p0, exp_perr);
         check("rnd_ferr", ferr_cnt - f0, exp_ferr);
         check("rnd_no_ovf", overflow, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
